counter_seq_ctrl: RTL and testbench

Sequencer for the 4-bit up/down counter datapath. It replaces the divided-clock scheme with a single-clock prescaled tick and drives the counter's enable, direction and load controls, so every flop runs on `clk`. It runs one of three count patterns between programmable limits (up-wrap, down-wrap, ping-pong) under start/stop control. It watches the counter value `cnt_q` to decide when a limit is reached.

---
 rtl/counter_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Single-clock sequencer for the 4-bit up/down counter: prescaled tick, run patterns
// (up-wrap, down-wrap, ping-pong) between latched limits, start/stop control.
module counter_seq_ctrl #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic [3:0] cnt_q,
    output logic       cnt_en,
    output logic       cnt_dir,
    output logic       cnt_load,
    output logic [3:0] cnt_ld_val,
    output logic       busy,
    output logic       wrap,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN
    } state_t;

    typedef enum logic [1:0] {
        M_UPWRAP   = 2'b00,
        M_DNWRAP   = 2'b01,
        M_PINGPONG = 2'b10,
        M_RSVD     = 2'b11
    } mode_t;

    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    state_t        r_state;
    mode_t         r_mode;
    logic [3:0]    r_lo;
    logic [3:0]    r_hi;
    logic [PW-1:0] r_pre;
    logic          r_cfg_err;

    logic       w_tick;
    logic       w_run;
    logic       w_reject;
    logic       w_en;
    logic       w_dir;
    logic       w_load;
    logic [3:0] w_ld_val;
    logic       w_wrap;
    logic       w_flip;

    assign w_tick   = ((r_state == S_UP) || (r_state == S_DOWN)) && (r_pre == PRE_LAST);
    assign w_run    = rst & ~stop;
    assign w_reject = (lo > hi) || (mode == M_RSVD);

    always_comb begin
        w_en     = 1'b0;
        w_dir    = 1'b0;
        w_load   = 1'b0;
        w_ld_val = '0;
        w_wrap   = 1'b0;
        w_flip   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_load = 1'b1;
                if (r_mode == M_DNWRAP) begin
                    w_ld_val = r_hi;
                    w_dir    = 1'b1;
                end else begin
                    w_ld_val = r_lo;
                end
            end
            S_UP: begin
                if (w_tick) begin
                    if (r_lo == r_hi) begin
                        w_load   = 1'b1;
                        w_ld_val = r_lo;
                        w_wrap   = 1'b1;
                    end else if (cnt_q != r_hi) begin
                        w_en = 1'b1;
                    end else if (r_mode == M_PINGPONG) begin
                        // Step straight off the limit so it is not repeated.
                        w_en   = 1'b1;
                        w_dir  = 1'b1;
                        w_wrap = 1'b1;
                        w_flip = 1'b1;
                    end else begin
                        w_load   = 1'b1;
                        w_ld_val = r_lo;
                        w_wrap   = 1'b1;
                    end
                end
            end
            S_DOWN: begin
                w_dir = 1'b1;
                if (w_tick) begin
                    if (r_lo == r_hi) begin
                        w_load   = 1'b1;
                        w_ld_val = r_lo;
                        w_wrap   = 1'b1;
                    end else if (cnt_q != r_lo) begin
                        w_en = 1'b1;
                    end else if (r_mode == M_PINGPONG) begin
                        w_en   = 1'b1;
                        w_dir  = 1'b0;
                        w_wrap = 1'b1;
                        w_flip = 1'b1;
                    end else begin
                        w_load   = 1'b1;
                        w_ld_val = r_hi;
                        w_wrap   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // A stop in the same cycle suppresses any step, load or wrap; reset blanks everything.
    assign cnt_en     = w_en & w_run;
    assign cnt_load   = w_load & w_run;
    assign wrap       = w_wrap & w_run;
    assign cnt_dir    = w_dir & rst;
    assign cnt_ld_val = rst ? w_ld_val : '0;
    assign busy       = rst & (r_state != S_IDLE);
    assign cfg_err    = r_cfg_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= M_UPWRAP;
            r_lo      <= '0;
            r_hi      <= '0;
            r_pre     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pre <= '0;
                    if (!stop && start) begin
                        if (w_reject) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_lo    <= lo;
                            r_hi    <= hi;
                            r_mode  <= mode_t'(mode);
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_pre <= '0;
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (r_mode == M_DNWRAP) begin
                        r_state <= S_DOWN;
                    end else begin
                        r_state <= S_UP;
                    end
                end
                S_UP, S_DOWN: begin
                    if (stop) begin
                        r_pre   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_pre <= w_tick ? '0 : r_pre + PW'(1);
                        if (w_flip) begin
                            r_state <= (r_state == S_UP) ? S_DOWN : S_UP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench: two sequencers (DIV=1 and DIV=2) each closing the loop through a
// behavioural 4-bit counter; per-cycle expectations are hand-computed tables.
module tb_counter_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] lo;
    logic [3:0] hi;

    logic [3:0] cnt1, cnt2;
    logic       en1, dir1, ld1, busy1, wrap1, err1;
    logic       en2, dir2, ld2, busy2, wrap2, err2;
    logic [3:0] ldv1, ldv2;

    int n_vec = 0;
    int n_mis = 0;

    // Table entry: {cnt_q[3:0], cnt_en, cnt_dir, cnt_load, wrap}
    logic [7:0] t_up [0:8] = '{8'h30, 8'h38, 8'h40, 8'h48, 8'h50, 8'h53, 8'h30, 8'h38, 8'h40};
    logic [7:0] t_pp [0:6] = '{8'h28, 8'h38, 8'h4D, 8'h3C, 8'h29, 8'h38, 8'h4D};
    logic [7:0] t_dn [0:5] = '{8'h2C, 8'h1C, 8'h07, 8'h2C, 8'h1C, 8'h07};

    counter_seq_ctrl #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .lo(lo), .hi(hi),
        .cnt_q(cnt1), .cnt_en(en1), .cnt_dir(dir1), .cnt_load(ld1), .cnt_ld_val(ldv1),
        .busy(busy1), .wrap(wrap1), .cfg_err(err1)
    );

    counter_seq_ctrl #(.DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .lo(lo), .hi(hi),
        .cnt_q(cnt2), .cnt_en(en2), .cnt_dir(dir2), .cnt_load(ld2), .cnt_ld_val(ldv2),
        .busy(busy2), .wrap(wrap2), .cfg_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (ld1) cnt1 <= ldv1;
            else if (en1) cnt1 <= dir1 ? cnt1 - 4'd1 : cnt1 + 4'd1;
            if (ld2) cnt2 <= ldv2;
            else if (en2) cnt2 <= dir2 ? cnt2 - 4'd1 : cnt2 + 4'd1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input bit use1, input logic [7:0] v);
        logic [3:0] c;
        logic       e, d, l, w;
        if (use1) begin
            c = cnt1; e = en1; d = dir1; l = ld1; w = wrap1;
        end else begin
            c = cnt2; e = en2; d = dir2; l = ld2; w = wrap2;
        end
        check({tag, ".cnt"},  32'(c), 32'(v[7:4]));
        check({tag, ".en"},   32'(e), 32'(v[3]));
        check({tag, ".dir"},  32'(d), 32'(v[2]));
        check({tag, ".load"}, 32'(l), 32'(v[1]));
        check({tag, ".wrap"}, 32'(w), 32'(v[0]));
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; stop = 1'b0; mode = 2'b00; lo = 4'd3; hi = 4'd5;

        repeat (3) begin
            step;
            check("rst.out1", 32'({busy1, en1, ld1, wrap1, err1, dir1, ldv1}), 32'd0);
            check("rst.out2", 32'({busy2, en2, ld2, wrap2, err2, dir2, ldv2}), 32'd0);
        end

        // Up-wrap on DIV=2: start is accepted on the first cycle out of reset
        rst = 1'b1;
        step;
        check("up.load", 32'(ld2), 32'd1);
        check("up.ldval", 32'(ldv2), 32'd3);
        check("up.busy", 32'(busy2), 32'd1);
        start = 1'b0;
        step;
        for (int i = 0; i < 9; i++) begin
            check_vec("up", 1'b0, t_up[i]);
            step;
        end

        // Stop lands on a tick with cnt_q=4
        stop = 1'b1;
        #1;
        check_vec("stop", 1'b0, 8'h40);
        check("stop.busy_same", 32'(busy2), 32'd1);
        step;
        stop = 1'b0;
        check("stop.busy_next", 32'(busy2), 32'd0);
        check("stop.hold", 32'(cnt2), 32'd4);
        step;
        check("stop.hold2", 32'(cnt2), 32'd4);

        start = 1'b1;
        step;
        start = 1'b0;
        check("restart.load", 32'(ld2), 32'd1);
        check("restart.ldval", 32'(ldv2), 32'd3);
        step;
        check("restart.cnt", 32'(cnt2), 32'd3);
        stop = 1'b1;
        step;
        stop = 1'b0;
        check("restart.idle", 32'(busy2), 32'd0);

        // Ping-pong on DIV=1
        mode = 2'b10; lo = 4'd2; hi = 4'd4; start = 1'b1;
        step;
        start = 1'b0;
        check("pp.load", 32'(ld1), 32'd1);
        check("pp.ldval", 32'(ldv1), 32'd2);
        step;
        for (int i = 0; i < 7; i++) begin
            check_vec("pp", 1'b1, t_pp[i]);
            step;
        end
        stop = 1'b1;
        step;
        stop = 1'b0;

        // Down-wrap on DIV=1
        mode = 2'b01; lo = 4'd0; hi = 4'd2; start = 1'b1;
        step;
        start = 1'b0;
        check("dn.load", 32'(ld1), 32'd1);
        check("dn.ldval", 32'(ldv1), 32'd2);
        check("dn.dir", 32'(dir1), 32'd1);
        step;
        for (int i = 0; i < 6; i++) begin
            check_vec("dn", 1'b1, t_dn[i]);
            step;
        end
        stop = 1'b1;
        step;
        stop = 1'b0;

        // lo=hi in ping-pong: reload every tick, never flip
        mode = 2'b10; lo = 4'd7; hi = 4'd7; start = 1'b1;
        step;
        start = 1'b0;
        check("eq.ldval", 32'(ldv1), 32'd7);
        step;
        check_vec("eq0", 1'b1, 8'h73);
        step;
        check_vec("eq1", 1'b1, 8'h73);
        check("eq.ldval2", 32'(ldv1), 32'd7);
        stop = 1'b1;
        step;
        stop = 1'b0;

        // Rejections
        mode = 2'b00; lo = 4'd6; hi = 4'd2; start = 1'b1;
        #1;
        check("rej_lohi.pre", 32'(err1), 32'd0);
        step;
        start = 1'b0;
        check("rej_lohi.err1", 32'(err1), 32'd1);
        check("rej_lohi.err2", 32'(err2), 32'd1);
        check("rej_lohi.busy", 32'(busy1), 32'd0);
        step;
        check("rej_lohi.pulse", 32'(err1), 32'd0);
        check("rej_lohi.busy2", 32'(busy1), 32'd0);

        mode = 2'b11; lo = 4'd1; hi = 4'd3; start = 1'b1;
        step;
        start = 1'b0;
        check("rej_mode.err", 32'(err1), 32'd1);
        check("rej_mode.busy", 32'(busy1), 32'd0);
        step;
        check("rej_mode.pulse", 32'(err1), 32'd0);

        mode = 2'b00; start = 1'b1; stop = 1'b1;
        step;
        start = 1'b0; stop = 1'b0;
        check("startstop.busy", 32'(busy1), 32'd0);
        check("startstop.err", 32'(err1), 32'd0);
        check("startstop.load", 32'(ld1), 32'd0);
        step;
        check("startstop.busy2", 32'(busy1), 32'd0);

        // Reset asserted mid-run
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        check("mid.en_before", 32'(en1), 32'd1);
        rst = 1'b0;
        #1;
        check("mid.en_gated", 32'(en1), 32'd0);
        step;
        rst = 1'b1;
        #1;
        check("mid.busy", 32'(busy1), 32'd0);
        step;
        check("mid.idle", 32'({busy1, en1, ld1}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
